// File: rtl/microop_issue.sv
// microop_issue
// Sequencing stage feeding a 4-bit logic micro-op unit. Incoming commands are
// buffered in a DEPTH-entry FIFO and issued one at a time; the accumulator
// drives the unit's x operand, the command data drives y, and the unit's
// combinational result d is written back into the accumulator and offered on
// a valid/ready result port.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_load, cmd_data  command fields {s1,s0}, load flag, operand
//   x, y, s0, s1             operands/select to the logic unit (registered)
//   d                        combinational result from the logic unit
//   res_valid/res_ready      result handshake
//   res_data                 result value
//   acc                      accumulator
//   busy                     FSM active or FIFO non-empty
module microop_issue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_load,
  input  logic [3:0] cmd_data,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic       s0,
  output logic       s1,
  input  logic [3:0] d,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [3:0] acc,
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT
  } state_t;

  state_t      state;
  logic [6:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [6:0]  rd_entry;

  logic        iss_load;
  logic [1:0]  iss_op;
  logic [3:0]  iss_data;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push     = cmd_valid && !full;
  assign pop      = !empty && ((state == IDLE) || ((state == WAIT) && res_ready));
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  assign x    = acc;
  assign y    = iss_data;
  assign s1   = iss_op[1];
  assign s0   = iss_op[0];
  assign busy = (state != IDLE) || !empty;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd_load, cmd_op, cmd_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= IDLE;
      iss_load  <= 1'b0;
      iss_op    <= '0;
      iss_data  <= '0;
      acc       <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {iss_load, iss_op, iss_data} <= rd_entry;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          acc       <= iss_load ? iss_data : d;
          res_data  <= iss_load ? iss_data : d;
          res_valid <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= empty ? IDLE : EXEC;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microop_issue.sv
module tb_microop_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_load;
  logic [3:0] cmd_data;
  logic [3:0] x;
  logic [3:0] y;
  logic       s0;
  logic       s1;
  logic [3:0] d;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [3:0] acc;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: accumulator advanced per accepted command, expected
  // result stream in command order, and the observed result stream.
  logic [3:0] acc_m;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int         got_cyc[$];

  microop_issue #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_load  (cmd_load),
    .cmd_data  (cmd_data),
    .x         (x),
    .y         (y),
    .s0        (s0),
    .s1        (s1),
    .d         (d),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .acc       (acc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Logic unit model.
  always_comb begin
    case ({s1, s0})
      2'b00:   d = x & y;
      2'b01:   d = x | y;
      2'b10:   d = x ^ y;
      default: d = ~x;
    endcase
  end

  function automatic logic [3:0] ref_next(input logic [3:0] a, input logic ld,
                                          input logic [1:0] op, input logic [3:0] dt);
    if (ld) return dt;
    case (op)
      2'd0:    return a & dt;
      2'd1:    return a | dt;
      2'd2:    return a ^ dt;
      default: return ~a;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_m <= '0;
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_m <= ref_next(acc_m, cmd_load, cmd_op, cmd_data);
        exp_q.push_back(ref_next(acc_m, cmd_load, cmd_op, cmd_data));
      end
      if (res_valid && res_ready) begin
        got_q.push_back(res_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [1:0] op, input logic [3:0] dt);
    cmd_load  = ld;
    cmd_op    = op;
    cmd_data  = dt;
    cmd_valid = 1'b1;
  endtask

  task automatic send(input logic ld, input logic [1:0] op, input logic [3:0] dt,
                      output bit to);
    bit ok;
    to = 1'b1;
    drive(ld, op, dt);
    for (int i = 0; i < 64; i++) begin
      ok = cmd_ready;
      tick();
      if (ok) begin
        to = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit to);
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (got_q.size() >= n && !busy) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_load = 1'b0; cmd_data = '0;
    res_ready = 1'b0;
    tick(); tick();
    total++; if (acc !== 4'h0 || x !== 4'h0) begin bad++;
      $display("FAIL reset_acc_x got acc=%h x=%h want 0", acc, x); end
    total++; if (y !== 4'h0 || {s1, s0} !== 2'b00) begin bad++;
      $display("FAIL reset_y_s got y=%h s=%b want 0", y, {s1, s0}); end
    total++; if (res_valid !== 1'b0 || res_data !== 4'h0) begin bad++;
      $display("FAIL reset_res got v=%b d=%h want 0", res_valid, res_data); end
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL reset_ready_busy got rdy=%b busy=%b want 1 0", cmd_ready, busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sequence();
    logic [3:0] want [5];
    bit to;
    int base;
    want[0] = 4'b1010; want[1] = 4'b1000; want[2] = 4'b1011;
    want[3] = 4'b0100; want[4] = 4'b1011;
    base = got_q.size();
    res_ready = 1'b1;
    send(1'b1, 2'b00, 4'b1010, to);                     // accepted at E0
    total++; if (to || res_valid !== 1'b0) begin bad++;
      $display("FAIL seq_accept got to=%b v=%b want 0 0", to, res_valid); end
    tick();                                             // E1: popped
    total++; if (y !== 4'b1010 || {s1, s0} !== 2'b00 || res_valid !== 1'b0) begin bad++;
      $display("FAIL seq_issue got y=%b s=%b v=%b want 1010 00 0", y, {s1, s0}, res_valid); end
    tick();                                             // E2: result
    total++; if (res_valid !== 1'b1 || res_data !== 4'b1010 || acc !== 4'b1010) begin bad++;
      $display("FAIL seq_latency got v=%b d=%b acc=%b want 1 1010 1010", res_valid, res_data, acc); end
    send(1'b0, 2'b00, 4'b1100, to);
    send(1'b0, 2'b01, 4'b0011, to);
    send(1'b0, 2'b10, 4'b1111, to);
    send(1'b0, 2'b11, 4'($urandom), to);
    wait_results(base + 5, to);
    total++; if (to || got_q.size() != base + 5) begin bad++;
      $display("FAIL seq_count got %0d want %0d", got_q.size() - base, 5); end
    for (int i = 0; i < 5; i++) begin
      if (got_q.size() > base + i) begin
        total++; if (got_q[base+i] !== want[i]) begin bad++;
          $display("FAIL seq_result[%0d] got %b want %b", i, got_q[base+i], want[i]); end
      end
    end
    for (int i = 2; i < 5; i++) begin
      if (got_cyc.size() > base + i) begin
        total++; if (got_cyc[base+i] - got_cyc[base+i-1] != 2) begin bad++;
          $display("FAIL seq_gap[%0d] got %0d want 2", i, got_cyc[base+i] - got_cyc[base+i-1]); end
      end
    end
    total++; if (acc !== 4'b1011) begin bad++;
      $display("FAIL seq_acc got %b want 1011", acc); end
  endtask

  task automatic test_issue_timing();
    logic [3:0] prev;
    bit to;
    int base;
    base = got_q.size();
    prev = acc_m;
    res_ready = 1'b1;
    send(1'b0, 2'b10, 4'b0110, to);
    tick();                                             // now in EXEC
    total++; if ({s1, s0} !== 2'b10 || y !== 4'b0110 || x !== prev) begin bad++;
      $display("FAIL issue_exec got s=%b y=%b x=%b want 10 0110 %b", {s1, s0}, y, x, prev); end
    @(negedge clk);
    total++; if ({s1, s0} !== 2'b10 || y !== 4'b0110 || x !== prev) begin bad++;
      $display("FAIL issue_mid got s=%b y=%b x=%b want 10 0110 %b", {s1, s0}, y, x, prev); end
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b1 || res_data !== (prev ^ 4'b0110) || acc !== (prev ^ 4'b0110)) begin bad++;
      $display("FAIL issue_result got v=%b d=%b acc=%b want 1 %b", res_valid, res_data, acc, prev ^ 4'b0110); end
    wait_results(base + 1, to);
    total++; if (to) begin bad++; $display("FAIL issue_drain got timeout want done"); end
  endtask

  task automatic test_backpressure();
    logic [6:0] c [4];
    bit to;
    int base;
    base = got_q.size();
    for (int i = 0; i < 4; i++) c[i] = 7'($urandom);
    res_ready = 1'b0;
    drive(c[0][6], c[0][5:4], c[0][3:0]); tick();      // E0
    total++; if (cmd_ready !== 1'b1) begin bad++;
      $display("FAIL bp_e0_ready got %b want 1", cmd_ready); end
    drive(c[1][6], c[1][5:4], c[1][3:0]); tick();      // E1: pop c0, push c1
    total++; if (cmd_ready !== 1'b1) begin bad++;
      $display("FAIL bp_e1_ready got %b want 1", cmd_ready); end
    drive(c[2][6], c[2][5:4], c[2][3:0]); tick();      // E2: FIFO full
    total++; if (cmd_ready !== 1'b0) begin bad++;
      $display("FAIL bp_full got %b want 0", cmd_ready); end
    drive(c[3][6], c[3][5:4], c[3][3:0]);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (cmd_ready !== 1'b0 || res_valid !== 1'b1) begin bad++;
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b want 0 1", i, cmd_ready, res_valid); end
    end
    total++; if (exp_q.size() != base + 3) begin bad++;
      $display("FAIL bp_fourth_held got accepted=%0d want 3", exp_q.size() - base); end
    res_ready = 1'b1;
    tick();                                             // pop frees an entry
    total++; if (cmd_ready !== 1'b1) begin bad++;
      $display("FAIL bp_release_ready got %b want 1", cmd_ready); end
    tick();                                             // fourth accepted
    cmd_valid = 1'b0;
    wait_results(base + 4, to);
    total++; if (to || got_q.size() != base + 4 || exp_q.size() != base + 4) begin bad++;
      $display("FAIL bp_count got %0d want 4", got_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > base + i && exp_q.size() > base + i) begin
        total++; if (got_q[base+i] !== exp_q[base+i]) begin bad++;
          $display("FAIL bp_result[%0d] got %b want %b", i, got_q[base+i], exp_q[base+i]); end
      end
    end
  endtask

  task automatic test_hold();
    logic [3:0] e;
    bit to;
    int base;
    base = got_q.size();
    res_ready = 1'b0;
    send(1'($urandom), 2'($urandom), 4'($urandom), to);
    for (int i = 0; i < 10 && !res_valid; i++) tick();
    e = (exp_q.size() > base) ? exp_q[base] : 4'hx;
    total++; if (res_valid !== 1'b1 || res_data !== e || acc !== e) begin bad++;
      $display("FAIL hold_first got v=%b d=%b acc=%b want 1 %b", res_valid, res_data, acc, e); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (res_valid !== 1'b1 || res_data !== e || acc !== e) begin bad++;
        $display("FAIL hold[%0d] got v=%b d=%b acc=%b want 1 %b", i, res_valid, res_data, acc, e); end
    end
    res_ready = 1'b1;
    wait_results(base + 1, to);
    total++; if (to || got_q.size() != base + 1) begin bad++;
      $display("FAIL hold_drain got %0d want 1", got_q.size() - base); end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    drive(1'b1, 2'b00, 4'($urandom)); tick();
    drive(1'b0, 2'($urandom), 4'($urandom)); tick();
    drive(1'b0, 2'($urandom), 4'($urandom)); tick();   // WAIT, FIFO full
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();                                             // EXEC, one still queued
    res_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (res_valid !== 1'b0 || acc !== 4'h0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++;
      $display("FAIL rstmid_now got v=%b acc=%h busy=%b rdy=%b want 0 0 0 1", res_valid, acc, busy, cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++;
        $display("FAIL rstmid_after[%0d] got v=%b busy=%b want 0 0", i, res_valid, busy); end
    end
    total++; if (got_q.size() != 0) begin bad++;
      $display("FAIL rstmid_stale got %0d results want 0", got_q.size()); end
  endtask

  task automatic test_simul_push_pop();
    bit to;
    int base;
    base = got_q.size();
    res_ready = 1'b0;
    drive(1'($urandom), 2'($urandom), 4'($urandom)); tick();  // a accepted
    drive(1'($urandom), 2'($urandom), 4'($urandom)); tick();  // a popped, b queued
    cmd_valid = 1'b0;
    tick();                                                   // WAIT
    res_ready = 1'b1;
    drive(1'($urandom), 2'($urandom), 4'($urandom));
    tick();                                                   // pop b, push c
    total++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || exp_q.size() != base + 3) begin bad++;
      $display("FAIL simul_edge got rdy=%b v=%b acc=%0d want 1 0 3", cmd_ready, res_valid, exp_q.size() - base); end
    res_ready = 1'b0;
    drive(1'($urandom), 2'($urandom), 4'($urandom));
    tick();                                                   // d fills FIFO
    total++; if (cmd_ready !== 1'b0) begin bad++;
      $display("FAIL simul_count got rdy=%b want 0", cmd_ready); end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_results(base + 4, to);
    total++; if (to || got_q.size() != base + 4) begin bad++;
      $display("FAIL simul_drain got %0d want 4", got_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > base + i && exp_q.size() > base + i) begin
        total++; if (got_q[base+i] !== exp_q[base+i]) begin bad++;
          $display("FAIL simul_result[%0d] got %b want %b", i, got_q[base+i], exp_q[base+i]); end
      end
    end
  endtask

  task automatic test_random();
    bit to;
    bit ok;
    int base;
    base = got_q.size();
    for (int n = 0; n < 400; n++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      if (!cmd_valid && $urandom_range(0, 2) != 0) begin
        drive(1'($urandom_range(0, 5) == 0), 2'($urandom), 4'($urandom));
      end
      ok = cmd_ready;
      tick();
      if (ok) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_results(exp_q.size(), to);
    total++; if (to || got_q.size() != exp_q.size() || got_q.size() <= base) begin bad++;
      $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = base; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL rand_result[%0d] got %b want %b", i, got_q[i], exp_q[i]); end
    end
    total++; if (acc !== acc_m) begin bad++;
      $display("FAIL rand_acc got %b want %b", acc, acc_m); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_issue_timing();
    test_backpressure();
    test_hold();
    test_reset_mid();
    test_simul_push_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
